// File: rtl/fetch_aligner.sv
// Instruction-fetch aligner for RV32IC: fetches aligned words, buffers them
// as halfwords and presents whole 16/32-bit instructions to decode.
module fetch_aligner #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_stall,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_compressed
);

   // Halfword FIFO; entry 0 is always the lowest address (head).
   logic [15:0] hw_buf_r [4];
   logic [2:0]  count_r;
   logic [31:0] head_pc_r;
   logic [31:0] fetch_addr_r;
   logic        skip_low_r;

   logic        head_is16_s;
   logic        have_instr_s;
   logic        consume_s;
   logic        push_s;
   logic [2:0]  pop_cnt_s;
   logic [2:0]  push_cnt_s;
   logic [2:0]  base_s;
   logic [3:0]  occ_s;
   logic [15:0] shifted_s [4];
   logic [15:0] next_buf_s [4];

   // Instruction length decode, consume/push decisions and fetch request.
   always_comb begin
      head_is16_s  = (hw_buf_r[0][1:0] != 2'b11);
      have_instr_s = head_is16_s ? (count_r >= 3'd1) : (count_r >= 3'd2);
      id_valid     = have_instr_s & ~redirect_valid;
      consume_s    = id_valid & ~id_stall;
      if (consume_s) begin
         pop_cnt_s = head_is16_s ? 3'd1 : 3'd2;
      end else begin
         pop_cnt_s = 3'd0;
      end
      push_s = imem_rvalid & ~redirect_valid;
      if (push_s) begin
         push_cnt_s = skip_low_r ? 3'd1 : 3'd2;
      end else begin
         push_cnt_s = 3'd0;
      end
      base_s = count_r - pop_cnt_s;
      occ_s  = {1'b0, count_r} - {1'b0, pop_cnt_s} + {1'b0, push_cnt_s};
      // Occupancy after this cycle <= 2 leaves room for the next full word.
      imem_req = ~rst & (redirect_valid | (occ_s <= 4'd2));
      if (redirect_valid) begin
         imem_addr = redirect_pc & 32'hFFFF_FFFC;
      end else begin
         imem_addr = fetch_addr_r;
      end
   end

   // Next buffer contents: pop from the head first, then append the response.
   always_comb begin
      case (pop_cnt_s)
         3'd1:    shifted_s = '{hw_buf_r[1], hw_buf_r[2], hw_buf_r[3], 16'h0000};
         3'd2:    shifted_s = '{hw_buf_r[2], hw_buf_r[3], 16'h0000, 16'h0000};
         default: shifted_s = hw_buf_r;
      endcase
      for (int i = 0; i < 4; i++) begin
         if (push_s && skip_low_r && (3'(i) == base_s)) begin
            next_buf_s[i] = imem_rdata[31:16];
         end else if (push_s && !skip_low_r && (3'(i) == base_s)) begin
            next_buf_s[i] = imem_rdata[15:0];
         end else if (push_s && !skip_low_r && (3'(i) == base_s + 3'd1)) begin
            next_buf_s[i] = imem_rdata[31:16];
         end else begin
            next_buf_s[i] = shifted_s[i];
         end
      end
   end

   // Decode-facing view taken purely from buffered state.
   always_comb begin
      id_pc         = head_pc_r;
      id_compressed = (count_r != 3'd0) & head_is16_s;
      if (count_r == 3'd0) begin
         id_instr = 32'h0000_0000;
      end else if (head_is16_s) begin
         id_instr = {16'h0000, hw_buf_r[0]};
      end else begin
         id_instr = {hw_buf_r[1], hw_buf_r[0]};
      end
   end

   // Buffer, pc and fetch pointer state; redirect overrides stall and consume.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            hw_buf_r[i] <= 16'h0000;
         end
         count_r      <= 3'd0;
         head_pc_r    <= RESET_PC;
         fetch_addr_r <= RESET_PC & 32'hFFFF_FFFC;
         skip_low_r   <= RESET_PC[1];
      end else if (redirect_valid) begin
         for (int i = 0; i < 4; i++) begin
            hw_buf_r[i] <= 16'h0000;
         end
         count_r      <= 3'd0;
         head_pc_r    <= redirect_pc & 32'hFFFF_FFFE;
         fetch_addr_r <= (redirect_pc & 32'hFFFF_FFFC) + 32'd4;
         skip_low_r   <= redirect_pc[1];
      end else begin
         hw_buf_r  <= next_buf_s;
         count_r   <= occ_s[2:0];
         head_pc_r <= head_pc_r + {28'h000_0000, pop_cnt_s, 1'b0};
         if (imem_req) begin
            fetch_addr_r <= fetch_addr_r + 32'd4;
         end
         if (push_s) begin
            skip_low_r <= 1'b0;
         end
      end
   end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction-fetch stage of the RV32IC pipeline. Sits between instruction memory and the decode pipeline register; produces the decode stage's pc/instruction pair.
- Fetches aligned 32-bit words and buffers them as halfwords.
- Realigns mixed 16/32-bit instructions, including 32-bit instructions that straddle a word boundary.
- Handles decode stalls and branch/jump redirects from EX.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch pc after reset (halfword aligned).

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous active-high reset
- imem_req  out  1  read request this cycle
- imem_addr  out  32  word address of the request, bits [1:0] always 0
- imem_rvalid  in  1  response valid; asserted exactly one cycle after imem_req
- imem_rdata  in  32  response word; low halfword is at the lower address
- redirect_valid  in  1  branch/jump taken in EX
- redirect_pc  in  32  target pc; bit 0 ignored (treated as 0)
- id_stall  in  1  decode cannot accept this cycle
- id_valid  out  1  id_pc/id_instr hold a complete instruction
- id_pc  out  32  pc of the presented instruction
- id_instr  out  32  instruction; compressed form is {16'h0, hw}
- id_compressed  out  1  presented instruction is 16-bit

Behaviour:
- Reset state:
  - buffer empty (count=0), head_pc=RESET_PC
  - fetch_addr={RESET_PC[31:2],2'b00}, skip_low=RESET_PC[1]
  - imem_req=0, id_valid=0, id_pc=RESET_PC, id_instr=0, id_compressed=0
- Buffer: 4 halfword entries, FIFO order, count 0..4. Head entry = lowest address.
- Instruction length:
  - head[1:0]!=2'b11 → 16-bit; needs count>=1.
  - else 32-bit; needs count>=2, with id_instr={entry1,entry0}.
- id_valid is true when the length rule is met and redirect_valid=0.
- id_* outputs come from registered buffer state only; no memory-to-output bypass.
- Consume happens when id_valid & !id_stall:
  - pop 1 or 2 entries
  - head_pc += 2 (16-bit) or 4 (32-bit)
- Response push happens when imem_rvalid & !redirect_valid:
  - push low then high halfword
  - if skip_low=1, push only the high halfword and clear skip_low
- Request issue:
  - imem_req=1 iff count - popped + pushed <= 2 in this cycle (occupancy after this cycle's pop and push), or redirect_valid=1.
  - On issue, fetch_addr += 4 (next cycle).
  - The buffer never overflows: at most one response is in flight.
- Redirect (priority over stall and consume):
  - buffer cleared; any imem_rvalid data that cycle is discarded
  - head_pc=redirect_pc
  - imem_req=1 with imem_addr={redirect_pc[31:2],2'b00} in the same cycle
  - fetch_addr=that address+4
  - skip_low=redirect_pc[1]
- Redirect latency:
  - Redirect at cycle t: first id_valid at t+2.
  - Exception: t+3 when redirect_pc[1]=1 and the target is a 32-bit instruction.
- Stall:
  - id_* held stable while id_stall=1 and no redirect.
  - Fetch continues until the buffer reaches 4 entries, then imem_req=0.
- Simultaneous events:
  - Pop and push in the same cycle: pop first, then push into the freed positions.
  - Redirect together with consume: the consume is ignored.
- Steady state: sequential aligned 32-bit code sustains one instruction per cycle.
- Straddle case: a 32-bit instruction whose low half is the last buffered entry waits (id_valid=0) until the next word arrives.
- Wrap-around: fetch_addr and head_pc wrap modulo 2^32 with no special handling.
- Reset mid-operation: asynchronously returns to the reset state; any response in flight is discarded because imem_rvalid is ignored while rst=1.

Test Plan:
- Reset with RESET_PC=0, memory word0=32'h00500093, word1=32'h00A00113:
  - imem_req first cycle after reset, addr 0 then 4
  - id_valid at cycle 2: pc 0, instr 00500093
  - next cycle: pc 4, instr 00A00113, id_compressed=0
- word0=32'h0093_4505 (c.li at 0, low half of 32-bit instr at 2), word1=32'h1234_0050:
  - pc 0: instr 0000_4505, id_compressed=1
  - then pc 2: instr 0050_0093, once word1 has arrived (the straddle wait applies only if word1 is not yet buffered)
  - then pc 6: 16-bit instr 0000_1234
- id_stall held 5 cycles during sequential 32-bit stream:
  - id_pc/id_instr stable throughout
  - imem_req drops once count=4
  - no instruction lost or duplicated after release
- Redirect to 32'h0000_0102 at cycle t while a response is in flight:
  - old data discarded; imem_addr=0x100 at t
  - low halfword skipped
  - id_pc=0x102 at t+2 if that instruction is 16-bit, t+3 if 32-bit
- Redirect asserted with id_stall=1 and a full buffer: buffer flushed, no old-path instruction ever presented after t.
- Assert rst for one cycle while id_valid=1 and a request is outstanding: outputs immediately at reset values, fetch restarts at RESET_PC.
